// File: rtl/multilayer_counter_p_pkg.sv
// Shared definitions for the multilayer prescaled up/down counter.
// Holds the counter mode constants and the layer-select clamp helper.
package multilayer_counter_p_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Selects beyond the last layer collapse onto the slowest tick.
    function automatic int unsigned clamp_sel(
        input int unsigned sel,
        input int unsigned layers
    );
        return (sel > layers) ? layers : sel;
    endfunction

endpackage

// File: rtl/multilayer_counter_p_prescaler.sv
// One modulo-DIV prescaler stage: advances on carry-in, carries out on wrap.
// Latency: cout is combinational from cin and the registered phase.
// Backpressure: none; a low cin freezes the stage.
module prescaler_layer
    import multilayer_counter_p_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic cin,
    output logic cout
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(DIV - 1);
    localparam logic [PW-1:0] P_ONE = PW'(1);

    logic [PW-1:0] p_q;
    logic [PW-1:0] p_d;

    always_comb begin
        p_d = p_q;
        if (clr) begin
            p_d = '0;
        end else if (cin) begin
            p_d = (p_q == P_MAX) ? '0 : p_q + P_ONE;
        end
    end

    assign cout = cin & (p_q == P_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

endmodule

// File: rtl/multilayer_counter_p.sv
// Up/down counter stepping on the tick of a selectable cascaded prescaler layer.
// Latency: q and tc update one edge after the step condition.
// Backpressure: none; ce=0 freezes prescaler and q, ld reloads and rephases.
module multilayer_counter_p
    import multilayer_counter_p_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int LAYERS   = 4,
    parameter int DIV      = 4,
    parameter int SEL_W    = 6,
    parameter int SATURATE = 0
) (
    input  logic             c,
    input  logic             r,
    input  logic             ce,
    input  logic [SEL_W-1:0] s,
    input  logic             dir,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] Q_ONE = WIDTH'(1);

    logic [LAYERS:0]    tick;
    logic               step;
    logic               at_limit;
    int unsigned        sel_idx;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   q_d;
    logic               tc_q;
    logic               tc_d;

    // tick[k+1] is tick[k] gated by layer k sitting at its last phase.
    assign tick[0] = ce;

    for (genvar k = 0; k < LAYERS; k++) begin : g_layer
        prescaler_layer #(
            .DIV (DIV)
        ) u_layer (
            .clk  (c),
            .rst  (r),
            .clr  (ld),
            .cin  (tick[k]),
            .cout (tick[k+1])
        );
    end

    always_comb begin
        sel_idx = clamp_sel(32'(s), LAYERS);
        step    = 1'b0;
        for (int k = 0; k <= LAYERS; k++) begin
            if (sel_idx == k) begin
                step = tick[k];
            end
        end
    end

    always_comb begin
        q_d      = q_q;
        tc_d     = 1'b0;
        at_limit = dir ? (q_q == '0) : (q_q == '1);
        if (ld) begin
            q_d = d;
        end else if (step) begin
            tc_d = at_limit;
            if (!(at_limit && (SATURATE == MODE_SAT))) begin
                q_d = dir ? (q_q - Q_ONE) : (q_q + Q_ONE);
            end
        end
    end

    always_ff @(posedge c) begin
        if (r) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign q  = q_q;
    assign tc = tc_q;

endmodule

// File: tb/tb_multilayer_counter_p.sv
// Directed bench: wrapping and saturating instances driven with the same stimulus.
module tb_multilayer_counter_p;

    logic       c = 1'b0;
    logic       r = 1'b0;
    logic       ce = 1'b0;
    logic [5:0] s = '0;
    logic       dir = 1'b0;
    logic       ld = 1'b0;
    logic [7:0] d = '0;
    logic [7:0] q_w;
    logic       tc_w;
    logic [7:0] q_s;
    logic       tc_s;

    int tests = 0;
    int fails = 0;

    always #5 c = ~c;

    multilayer_counter_p #(
        .WIDTH(8), .LAYERS(4), .DIV(4), .SEL_W(6), .SATURATE(0)
    ) dut_w (
        .c(c), .r(r), .ce(ce), .s(s), .dir(dir), .ld(ld), .d(d), .q(q_w), .tc(tc_w)
    );

    multilayer_counter_p #(
        .WIDTH(8), .LAYERS(4), .DIV(4), .SEL_W(6), .SATURATE(1)
    ) dut_s (
        .c(c), .r(r), .ce(ce), .s(s), .dir(dir), .ld(ld), .d(d), .q(q_s), .tc(tc_s)
    );

    task automatic edges(input int n);
        repeat (n) begin
            @(posedge c);
            #1;
        end
    endtask

    task automatic do_reset();
        r = 1'b1; ld = 1'b0; ce = 1'b0; dir = 1'b0; s = '0;
        edges(1);
        r = 1'b0;
    endtask

    task automatic test_reset();
        r = 1'b1; ld = 1'b1; d = 8'h55; ce = 1'b1; s = '0;
        edges(2);
        r = 1'b0; ld = 1'b0; ce = 1'b0;
        tests++;
        if (q_w !== 8'h00) begin
            fails++; $display("FAIL reset_q_w: got %0h expected 00", q_w);
        end
        tests++;
        if (tc_w !== 1'b0 || tc_s !== 1'b0) begin
            fails++; $display("FAIL reset_tc: got %0b/%0b expected 0/0", tc_w, tc_s);
        end
        tests++;
        if (q_s !== 8'h00) begin
            fails++; $display("FAIL reset_q_s: got %0h expected 00", q_s);
        end
    endtask

    task automatic test_wrap_layer0();
        int bad = 0;
        do_reset();
        ce = 1'b1; s = 6'd0; dir = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            edges(1);
            if (tc_w !== (i == 256)) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL wrap_tc_pulse: got %0d bad cycles expected 0", bad);
        end
        tests++;
        if (q_w !== 8'd44) begin
            fails++; $display("FAIL wrap_q_300: got %0d expected 44", q_w);
        end
        tests++;
        if (q_s !== 8'd255) begin
            fails++; $display("FAIL sat_q_300: got %0d expected 255", q_s);
        end
    endtask

    task automatic test_layer_select();
        do_reset();
        ce = 1'b1; s = 6'd1;
        edges(40);
        tests++;
        if (q_w !== 8'd10) begin
            fails++; $display("FAIL sel1_q: got %0d expected 10", q_w);
        end
        s = 6'd2;
        edges(64);
        tests++;
        if (q_w !== 8'd14) begin
            fails++; $display("FAIL sel2_q: got %0d expected 14", q_w);
        end
    endtask

    task automatic test_sel_change();
        do_reset();
        ce = 1'b1; s = 6'd0;
        edges(2);
        tests++;
        if (q_w !== 8'd2) begin
            fails++; $display("FAIL selchg_pre: got %0d expected 2", q_w);
        end
        s = 6'd1;
        edges(1);
        tests++;
        if (q_w !== 8'd2) begin
            fails++; $display("FAIL selchg_p0_2: got %0d expected 2", q_w);
        end
        edges(1);
        tests++;
        if (q_w !== 8'd3) begin
            fails++; $display("FAIL selchg_p0_3: got %0d expected 3", q_w);
        end
    endtask

    task automatic test_clamp();
        do_reset();
        ce = 1'b1; s = 6'd63;
        edges(255);
        tests++;
        if (q_w !== 8'd0) begin
            fails++; $display("FAIL clamp_255: got %0d expected 0", q_w);
        end
        edges(1);
        tests++;
        if (q_w !== 8'd1) begin
            fails++; $display("FAIL clamp_256: got %0d expected 1", q_w);
        end
        edges(255);
        tests++;
        if (q_w !== 8'd1) begin
            fails++; $display("FAIL clamp_511: got %0d expected 1", q_w);
        end
        edges(1);
        tests++;
        if (q_w !== 8'd2) begin
            fails++; $display("FAIL clamp_512: got %0d expected 2", q_w);
        end
    endtask

    task automatic test_down_wrap();
        ce = 1'b0; ld = 1'b1; d = 8'h00;
        edges(1);
        ld = 1'b0;
        tests++;
        if (q_w !== 8'h00 || tc_w !== 1'b0) begin
            fails++; $display("FAIL down_load: got %0h/%0b expected 00/0", q_w, tc_w);
        end
        dir = 1'b1; s = 6'd0; ce = 1'b1;
        edges(1);
        tests++;
        if (q_w !== 8'hFF || tc_w !== 1'b1) begin
            fails++; $display("FAIL down_wrap: got %0h/%0b expected ff/1", q_w, tc_w);
        end
        tests++;
        if (q_s !== 8'h00 || tc_s !== 1'b1) begin
            fails++; $display("FAIL down_sat: got %0h/%0b expected 00/1", q_s, tc_s);
        end
        ce = 1'b0;
        edges(10);
        tests++;
        if (q_w !== 8'hFF || tc_w !== 1'b0) begin
            fails++; $display("FAIL ce_hold: got %0h/%0b expected ff/0", q_w, tc_w);
        end
        dir = 1'b0;
    endtask

    task automatic test_saturate();
        logic [7:0] exp_w;
        ce = 1'b0; ld = 1'b1; d = 8'hFE;
        edges(1);
        ld = 1'b0; dir = 1'b0; s = 6'd0; ce = 1'b1;
        exp_w = 8'hFE;
        for (int i = 1; i <= 4; i++) begin
            edges(1);
            exp_w = exp_w + 8'd1;
            tests++;
            if (q_s !== 8'hFF || tc_s !== (i >= 2)) begin
                fails++; $display("FAIL sat_step%0d: got %0h/%0b expected ff/%0b", i, q_s, tc_s, i >= 2);
            end
            tests++;
            if (q_w !== exp_w || tc_w !== (i == 2)) begin
                fails++; $display("FAIL wrap_step%0d: got %0h/%0b expected %0h/%0b", i, q_w, tc_w, exp_w, i == 2);
            end
        end
        ld = 1'b1; d = 8'h20;
        edges(1);
        ld = 1'b0;
        tests++;
        if (q_s !== 8'h20 || tc_s !== 1'b0) begin
            fails++; $display("FAIL ld_clears_tc: got %0h/%0b expected 20/0", q_s, tc_s);
        end
        ce = 1'b0;
    endtask

    task automatic test_r_ld();
        do_reset();
        ce = 1'b1; s = 6'd0; dir = 1'b0;
        edges(5);
        r = 1'b1; ld = 1'b1; d = 8'h55;
        edges(1);
        r = 1'b0; ld = 1'b0;
        tests++;
        if (q_w !== 8'h00 || tc_w !== 1'b0) begin
            fails++; $display("FAIL r_over_ld: got %0h/%0b expected 00/0", q_w, tc_w);
        end
        s = 6'd1;
        edges(3);
        tests++;
        if (q_w !== 8'h00) begin
            fails++; $display("FAIL r_clears_p_3: got %0h expected 00", q_w);
        end
        edges(1);
        tests++;
        if (q_w !== 8'h01) begin
            fails++; $display("FAIL r_clears_p_4: got %0h expected 01", q_w);
        end
        ld = 1'b1;
        edges(1);
        ld = 1'b0;
        tests++;
        if (q_w !== 8'h55) begin
            fails++; $display("FAIL ld_alone: got %0h expected 55", q_w);
        end
        edges(3);
        ld = 1'b1; d = 8'h10;
        edges(1);
        ld = 1'b0;
        tests++;
        if (q_w !== 8'h10) begin
            fails++; $display("FAIL ld_over_step: got %0h expected 10", q_w);
        end
        edges(3);
        tests++;
        if (q_w !== 8'h10) begin
            fails++; $display("FAIL ld_clears_p_3: got %0h expected 10", q_w);
        end
        edges(1);
        tests++;
        if (q_w !== 8'h11) begin
            fails++; $display("FAIL ld_clears_p_4: got %0h expected 11", q_w);
        end
        ce = 1'b0;
    endtask

    initial begin
        edges(1);
        test_reset();
        test_wrap_layer0();
        test_layer_select();
        test_sel_change();
        test_clamp();
        test_down_wrap();
        test_saturate();
        test_r_ld();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
